// File: rtl/exp_taylor_unit.sv
// Fixed-point e^x (x in [0,1)) by iterative Taylor series, one term per clock.
// Build option: define EXP_SAT_EN to clamp the accumulator on overflow instead of wrapping.
module exp_taylor_unit #(
   parameter int XW    = 16,
   parameter int FW    = 16,
   parameter int IW    = 2,
   parameter int TERMS = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [XW-1:0] x,
   output logic          busy,
   output logic          done,
   output logic [IW-1:0] intpart,
   output logic [FW-1:0] fracpart,
   output logic [1:0]    dbg_state_o
);

   // Handshake: start is sampled on a rising edge only in IDLE or DONE; while busy
   // it is ignored. done is a one-cycle pulse, result held until the next completion.

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam int KW = $clog2(TERMS);
   localparam int AW = IW + FW;
   localparam int PXW = FW + XW + 1;
   localparam int PRW = 2 * FW + 2;

   localparam logic [FW:0]    ONE_TERM = {1'b1, {FW{1'b0}}};
   localparam logic [AW-1:0]  ONE_ACC  = AW'(1) << FW;
   localparam logic [KW-1:0]  K_FIRST  = KW'(1);
   localparam logic [KW-1:0]  K_LAST   = KW'(TERMS - 1);

   // recip_tab[k] = floor(2^FW / k); entry 0 is never addressed.
   logic [FW:0] recip_tab [TERMS];

   for (genvar g = 0; g < TERMS; g++) begin : g_recip
      assign recip_tab[g] = (g == 0) ? '0 : (FW+1)'((64'd1 << FW) / ((g == 0) ? 1 : g));
   end

   state_t         state_q;
   logic [XW-1:0]  x_q;
   logic [FW:0]    term_q;
   logic [AW-1:0]  acc_q;
   logic [KW-1:0]  k_q;
   logic           busy_q;
   logic           done_q;
   logic [AW-1:0]  res_q;

   logic [PXW-1:0] prod_x;
   logic [FW:0]    scaled;
   logic [PRW-1:0] prod_r;
   logic [FW:0]    term_d;
   logic [AW-1:0]  acc_d;

`ifdef EXP_SAT_EN
   logic           sat_q;
   logic           sat_d;
   logic [AW:0]    sum;
`endif

   // Both products truncate: term*x drops XW bits, then the 1/k scale drops FW bits.
   always_comb begin
      prod_x = PXW'(term_q) * PXW'(x_q);
      scaled = (FW+1)'(prod_x >> XW);
      prod_r = PRW'(scaled) * PRW'(recip_tab[k_q]);
      term_d = (FW+1)'(prod_r >> FW);
`ifdef EXP_SAT_EN
      sum    = {1'b0, acc_q} + (AW+1)'(term_d);
      sat_d  = sat_q | sum[AW];
      acc_d  = sat_d ? '1 : sum[AW-1:0];
`else
      acc_d  = acc_q + AW'(term_d);
`endif
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         x_q     <= '0;
         term_q  <= '0;
         acc_q   <= '0;
         k_q     <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         res_q   <= '0;
`ifdef EXP_SAT_EN
         sat_q   <= 1'b0;
`endif
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE, S_DONE: begin
               if (start) begin
                  x_q     <= x;
                  term_q  <= ONE_TERM;
                  acc_q   <= ONE_ACC;
                  k_q     <= K_FIRST;
                  busy_q  <= 1'b1;
                  state_q <= S_CALC;
`ifdef EXP_SAT_EN
                  sat_q   <= 1'b0;
`endif
               end else begin
                  state_q <= S_IDLE;
               end
            end
            S_CALC: begin
               term_q <= term_d;
               acc_q  <= acc_d;
               k_q    <= k_q + 1'b1;
`ifdef EXP_SAT_EN
               sat_q  <= sat_d;
`endif
               if (k_q == K_LAST) begin
                  res_q   <= acc_d;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= S_DONE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign busy        = busy_q;
   assign done        = done_q;
   assign intpart     = res_q[AW-1:FW];
   assign fracpart    = res_q[FW-1:0];
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_exp_taylor_unit.sv
// Bench for exp_taylor_unit: default (IW=2) and IW=1 instances driven in lockstep,
// results compared against a plain-arithmetic Taylor model and known e^x constants.
module tb_exp_taylor_unit;

   localparam int TERMS = 8;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [15:0] x;

   logic        busy2, done2;
   logic [1:0]  int2;
   logic [15:0] frac2;
   logic [1:0]  dbg2;

   logic        busy1, done1;
   logic [0:0]  int1;
   logic [15:0] frac1;
   logic [1:0]  dbg1;

   int n_checks = 0;
   int n_pass   = 0;

   logic [17:0] exp2_q[$];
   logic [16:0] exp1_q[$];
   logic [17:0] last2;
   logic [16:0] last1;

   always #5 clk = ~clk;

   exp_taylor_unit #(.XW(16), .FW(16), .IW(2), .TERMS(TERMS)) u_dut2 (
      .clk(clk), .rst(rst), .start(start), .x(x),
      .busy(busy2), .done(done2), .intpart(int2), .fracpart(frac2),
      .dbg_state_o(dbg2)
   );

   exp_taylor_unit #(.XW(16), .FW(16), .IW(1), .TERMS(TERMS)) u_dut1 (
      .clk(clk), .rst(rst), .start(start), .x(x),
      .busy(busy1), .done(done1), .intpart(int1), .fracpart(frac1),
      .dbg_state_o(dbg1)
   );

   // Series sum with truncating fixed-point products; result as Q(iw).16.
   function automatic longint unsigned ref_exp(input longint unsigned xv, input int iw);
      longint unsigned term, acc, lim;
      bit sat;
      term = 64'd1 << 16;
      acc  = term;
      lim  = (64'd1 << (iw + 16)) - 1;
      sat  = 1'b0;
      for (int k = 1; k < TERMS; k++) begin
         term = (((term * xv) >> 16) * ((64'd1 << 16) / k)) >> 16;
         acc  = acc + term;
`ifdef EXP_SAT_EN
         if (sat || acc > lim) begin
            sat = 1'b1;
            acc = lim;
         end
`else
         acc = acc & lim;
`endif
      end
      return acc;
   endfunction

   task automatic check_eq(input string tag, input longint unsigned got, input longint unsigned exp);
      n_checks++;
      if (got !== exp)
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      else
         n_pass++;
   endtask

   task automatic push_exp(input logic [15:0] xv);
      exp2_q.push_back(18'(ref_exp(64'(xv), 2)));
      exp1_q.push_back(17'(ref_exp(64'(xv), 1)));
   endtask

   task automatic begin_run(input logic [15:0] xv);
      start = 1'b1;
      x     = xv;
      push_exp(xv);
   endtask

   // Expects start/x already driven for this run. chain keeps start high through the
   // run with x = xnext, so the next run is accepted straight out of DONE.
   task automatic run_one(input logic [15:0] xv, input bit glitch, input bit chain,
                          input logic [15:0] xnext);
      logic [17:0] e2;
      logic [16:0] e1;
      @(posedge clk); #1;
      if (chain) begin
         x = xnext;
         push_exp(xnext);
      end else begin
         start = 1'b0;
         x     = 16'($urandom);
      end
      check_eq("busy_c1", busy2, 1);
      check_eq("done_c1", done2, 0);
      for (int c = 2; c <= TERMS - 1; c++) begin
         @(posedge clk); #1;
         check_eq("busy_calc", busy2, 1);
         check_eq("done_calc", done2, 0);
         if (glitch && !chain && c == 3) begin
            start = 1'b1;
            x     = ~xv;
         end
         if (glitch && !chain && c == 4) start = 1'b0;
      end
      @(posedge clk); #1;
      e2 = exp2_q.pop_front();
      e1 = exp1_q.pop_front();
      check_eq("done_pulse", done2, 1);
      check_eq("busy_done", busy2, 0);
      check_eq("result_iw2", {int2, frac2}, e2);
      check_eq("done_iw1", done1, 1);
      check_eq("result_iw1", {int1, frac1}, e1);
      last2 = {int2, frac2};
      last1 = {int1, frac1};
      if (!chain) begin
         @(posedge clk); #1;
         check_eq("done_clear", done2, 0);
         check_eq("idle_busy", busy2, 0);
         check_eq("result_held", {int2, frac2}, e2);
      end
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] cur, nxt;
      bit ch, gl;
      rst   = 1'b1;
      start = 1'b0;
      x     = '0;
      repeat (2) @(posedge clk);
      #1;
      check_eq("rst_busy", busy2, 0);
      check_eq("rst_done", done2, 0);
      check_eq("rst_int", int2, 0);
      check_eq("rst_frac", frac2, 0);
      check_eq("rst_state", dbg2, 0);
      check_eq("rst_state_iw1", dbg1, 0);
      rst = 1'b0;
      @(posedge clk); #1;

      // x = 0 gives exactly 1.0
      begin_run(16'h0000);
      run_one(16'h0000, 1'b0, 1'b0, 16'h0);
      check_eq("x0_int", last2[17:16], 1);
      check_eq("x0_frac", last2[15:0], 0);

      // e^0.5 is at most 16 LSB below 1.A612
      begin_run(16'h8000);
      run_one(16'h8000, 1'b0, 1'b0, 16'h0);
      check_eq("e05_tol", (last2 <= 18'h1A612) && (18'h1A612 - last2 <= 18'd16), 1);

      // e^~1 is at most 16 LSB below 2.B7DF; IW=1 clamps or wraps
      begin_run(16'hFFFF);
      run_one(16'hFFFF, 1'b0, 1'b0, 16'h0);
      check_eq("e1_tol", (last2 <= 18'h2B7DF) && (18'h2B7DF - last2 <= 18'd16), 1);
`ifdef EXP_SAT_EN
      check_eq("iw1_sat", last1, 17'h1FFFF);
`else
      check_eq("iw1_wrap_int", last1[16], 0);
      check_eq("iw1_wrap_tol", (last1 <= 17'h0B7DF) && (17'h0B7DF - last1 <= 17'd16), 1);
`endif

      // start pulse mid-run with new x is ignored
      begin_run(16'h4000);
      run_one(16'h4000, 1'b1, 1'b0, 16'h0);

      // reset three cycles into CALC aborts immediately
      start = 1'b1;
      x     = 16'h9ABC;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (3) begin
         @(posedge clk); #1;
      end
      rst = 1'b1;
      #1;
      check_eq("abort_busy", busy2, 0);
      check_eq("abort_done", done2, 0);
      check_eq("abort_int", int2, 0);
      check_eq("abort_frac", frac2, 0);
      check_eq("abort_state", dbg2, 0);
      #2;
      rst = 1'b0;
      @(posedge clk); #1;
      begin_run(16'hC350);
      run_one(16'hC350, 1'b0, 1'b0, 16'h0);

      // start held high: back-to-back runs out of DONE
      begin_run(16'h1234);
      run_one(16'h1234, 1'b0, 1'b1, 16'hC000);
      run_one(16'hC000, 1'b0, 1'b1, 16'h7777);
      run_one(16'h7777, 1'b0, 1'b0, 16'h0);

      // randomized runs
      cur = 16'($urandom);
      begin_run(cur);
      for (int i = 0; i < 24; i++) begin
         nxt = 16'($urandom);
         ch  = (i < 23) && ($urandom_range(0, 2) == 0);
         gl  = 1'($urandom_range(0, 1));
         run_one(cur, gl, ch, nxt);
         if (ch) begin
            cur = nxt;
         end else if (i < 23) begin
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
            cur = 16'($urandom);
            begin_run(cur);
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
